// File: rtl/theme_player.sv
// Theme PCM channel sequencer: paces a 20 kHz sample clock off the 640 kHz strobe, fetches one ROM byte per sample.
// Latency: rom_req rises 1 cycle after a sample tick; sample/sample_stb update 1 cycle after rom_ack.
// Backpressure: the ROM stalls via late rom_ack; ticks arriving while a fetch is pending are dropped and flagged in underrun.
//
// Ports:
//   main_clk, reset         clock and asynchronous active-high reset
//   ce_640k                 single-cycle 640 kHz clock enable
//   play_en                 level: 1 = play/continue, 0 = stop and rewind
//   rom_addr/rom_req        byte address and fetch request (held until rom_ack)
//   rom_ack/rom_data        single-cycle acknowledge with the data byte
//   sample/sample_stb       offset-binary PCM sample and its update strobe
//   busy/done/underrun      playing, finished, sticky missed-tick flag
//
// Build option: define THEME_VOLUME_EN to add a 4-bit vol input that scales
// the sample around the offset-binary midpoint; without it samples pass
// through verbatim.
module theme_player #(
  parameter int          ADDR_W     = 19,
  parameter int          TICK_PHASE = 16,
  parameter logic [7:0]  MUTE_VAL   = 8'h80
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              ce_640k,
  input  logic              play_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
`ifdef THEME_VOLUME_EN
  input  logic [3:0]        vol,
`endif
  output logic [7:0]        sample,
  output logic              sample_stb,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    FETCH     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [4:0] TICK_DIV = 5'(TICK_PHASE);

  state_t            state_q, state_d;
  logic [4:0]        div_q, div_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rom_req_q, rom_req_d;
  logic [7:0]        sample_q, sample_d;
  logic              stb_q, stb_d;
  logic              underrun_q, underrun_d;

  logic              tick;
  logic              ack_take;
  logic [ADDR_W-1:0] addr_inc;
  logic [7:0]        fetched_sample;

  // The divider is compared before it increments, so the tick lands on the
  // strobe that sees div == TICK_DIV.
  assign tick     = ce_640k && (div_q == TICK_DIV);
  // Acks only count against an outstanding request; stray acks are ignored.
  assign ack_take = rom_ack && rom_req_q && (state_q == FETCH);
  assign addr_inc = addr_q + ADDR_W'(1);

`ifdef THEME_VOLUME_EN
  // Re-centre the byte around zero, scale by (vol+1)/16 with an arithmetic
  // shift so negative excursions round toward minus infinity, then re-bias.
  logic signed [8:0]  centered;
  logic signed [5:0]  gain;
  logic signed [14:0] scaled_prod;

  always_comb begin
    centered       = $signed({1'b0, rom_data}) - 9'sd128;
    gain           = $signed({2'b00, vol} + 6'd1);
    scaled_prod    = centered * gain;
    fetched_sample = 8'(scaled_prod >>> 4) + 8'h80;
  end
`else
  assign fetched_sample = rom_data;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (play_en) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!play_en)  state_d = IDLE;
        else if (tick) state_d = FETCH;
      end
      FETCH: begin
        if (!play_en) begin
          state_d = IDLE;
        end else if (ack_take) begin
          // Finish as soon as the address MSB sets so the counter never wraps.
          state_d = addr_inc[ADDR_W-1] ? DONE : WAIT_TICK;
        end
      end
      DONE: begin
        // Only a drop of play_en re-arms playback; a held play_en never retriggers.
        if (!play_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy = (state_q == WAIT_TICK) || (state_q == FETCH);
    done = (state_q == DONE);
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    div_d      = div_q;
    addr_d     = addr_q;
    rom_req_d  = rom_req_q;
    sample_d   = sample_q;
    stb_d      = 1'b0;
    underrun_d = underrun_q;

    if (!play_en) begin
      // Stop and rewind from any state; a same-cycle ack is discarded and the
      // outstanding request is simply abandoned.
      div_d     = '0;
      addr_d    = '0;
      rom_req_d = 1'b0;
      sample_d  = MUTE_VAL;
    end else begin
      if ((state_q == WAIT_TICK) || (state_q == FETCH)) begin
        if (ce_640k) div_d = div_q + 5'd1;
      end else begin
        div_d = '0;
      end

      case (state_q)
        IDLE: begin
          addr_d     = '0;
          underrun_d = 1'b0;
          sample_d   = MUTE_VAL;
        end
        WAIT_TICK: begin
          if (tick) rom_req_d = 1'b1;
        end
        FETCH: begin
          // A tick here is lost: the pending fetch keeps its address and
          // completes normally, so no sample address is ever skipped.
          if (tick) underrun_d = 1'b1;
          if (ack_take) begin
            sample_d  = fetched_sample;
            stb_d     = 1'b1;
            addr_d    = addr_inc;
            rom_req_d = 1'b0;
          end
        end
        DONE: begin
          rom_req_d = 1'b0;
          sample_d  = MUTE_VAL;
        end
        default: begin
          rom_req_d = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      addr_q     <= '0;
      rom_req_q  <= 1'b0;
      sample_q   <= MUTE_VAL;
      stb_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      addr_q     <= addr_d;
      rom_req_q  <= rom_req_d;
      sample_q   <= sample_d;
      stb_q      <= stb_d;
      underrun_q <= underrun_d;
    end
  end

  assign rom_addr   = addr_q;
  assign rom_req    = rom_req_q;
  assign sample     = sample_q;
  assign sample_stb = stb_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/theme_player.md
Name: theme_player

Overview:
- Sequences the dedicated TMNT theme PCM playback channel.
- Derives the sample rate from the 640 kHz audio strobe.
- Walks the theme ROM address space and fetches one byte per sample through a req/ack ROM port.
- Presents offset-binary 8-bit samples to the audio mixer. Sits beside the Z80 sound section in the top level; playback is gated by the system's theme-enable control.

Parameters:
- ADDR_W, 19: ROM address counter width; playback ends when the counter's MSB sets (2^(ADDR_W-1) samples).
- TICK_PHASE, 16: 5-bit divider value on which a sample tick fires (one tick per 32 ce_640k strobes, 20 kHz).
- MUTE_VAL, 8'h80: sample output value while not playing (offset-binary zero).

Ports:
- main_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce_640k  in  1  one-main_clk-wide 640 kHz clock enable.
- play_en  in  1  level; 1 = play or continue, 0 = stop and rewind.
- rom_addr  out  ADDR_W  theme ROM byte address, stable while rom_req=1.
- rom_req  out  1  fetch request, held high until rom_ack.
- rom_ack  in  1  one-cycle pulse; rom_data valid in the same cycle.
- rom_data  in  8  ROM byte.
- sample  out  8  current PCM sample, offset binary.
- sample_stb  out  1  one-cycle pulse when sample updates.
- busy  out  1  high in WAIT_TICK/FETCH.
- done  out  1  high in DONE.
- underrun  out  1  sticky; set when a tick arrives with a fetch pending.

Behaviour:
- Reset values: rom_addr=0, rom_req=0, sample=MUTE_VAL, sample_stb=0, busy=0, done=0, underrun=0, div=0, state=IDLE.
- Divider: 5-bit div increments on ce_640k while state is WAIT_TICK or FETCH, and is held at 0 otherwise. tick = ce_640k & (div==TICK_PHASE), evaluated before the increment; wraps 31->0.
- States:
  - IDLE: play_en=1 -> WAIT_TICK; addr=0, underrun cleared.
  - WAIT_TICK: on tick -> FETCH, rom_req<=1 with the current addr.
  - FETCH: on rom_ack -> sample<=rom_data, sample_stb=1 the next cycle, addr<=addr+1. Then if the new addr MSB=1 -> DONE, else -> WAIT_TICK; rom_req<=0 in the same edge.
  - DONE: sample=MUTE_VAL; stays until play_en=0 -> IDLE. No retrigger while play_en stays high.
- Latency: rom_req rises 1 cycle after the tick; sample_stb rises 1 cycle after rom_ack.
- A tick while in FETCH sets underrun. The tick is dropped: no extra fetch, no address skip. rom_req stays high and the pending fetch completes normally.
- play_en=0 in any state: next cycle -> IDLE, rom_req=0, addr=0, div=0, sample=MUTE_VAL. An ack arriving the same cycle is ignored. The ROM port tolerates an abandoned request.
- rom_ack while rom_req=0 is ignored.
- Simultaneous rom_ack and tick in FETCH: the ack is taken and the tick is counted as underrun.
- The addr increment is ADDR_W-bit unsigned. The MSB check prevents wrap.
- busy = state is WAIT_TICK or FETCH.

Optional Feature:
- Macro: THEME_VOLUME_EN.
- Defined: adds input vol (4 bits). sample = (rom_byte-128)*(vol+1)/16 + 128, computed signed with arithmetic shift and registered at ack. vol=15 is unity; vol=0 gives 1/16 amplitude. MUTE_VAL is unaffected. Latency unchanged.
- Undefined: no vol port; sample = rom_data verbatim.

Test Plan:
- Reset, then play_en=1 and ce_640k every 37 cycles with ROM ack 2 cycles after req. Required: first rom_req at addr 0 on the 17th strobe; samples at addr 0,1,2 spaced 32 strobes apart; underrun=0.
- ROM model returns addr[7:0]. Required: sample_stb pulses with sample=00,01,02 and rom_addr=0,1,2 at each req.
- Ack delayed beyond 32 strobes. Required: underrun=1 sticky, rom_addr unchanged during the wait, next fetch at addr+1 with no skipped address.
- Force addr to 2^18-1 (ADDR_W=19). Required: after the ack, done=1, busy=0, sample=80, no further rom_req while play_en=1; play_en 1->0->1 restarts at addr 0 with underrun cleared.
- Drop play_en mid-FETCH with ack in the same cycle. Required: sample=80, rom_req=0 next cycle, state IDLE, ack data discarded.
- With THEME_VOLUME_EN: vol=7, rom_data=FF -> sample=BF; vol=15, rom_data=00 -> sample=00.
